// File: rtl/keypad_scan_encode_pkg.sv
// Shared types and defaults for the keypad scanner and the display scan driver.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_e;

  localparam int unsigned SCAN_DIV_1MS        = 50000;
  localparam int unsigned DEBOUNCE_FRAMES_DEF = 5;

  // Number of active-low rows reading 0.
  function automatic logic [2:0] count_low(input logic [3:0] rows);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest row reading 0 (0 when none do).
  function automatic logic [1:0] low_zero_idx(input logic [3:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_encode_if.sv
// Keypad pins plus the encoded key / digit-buffer outputs.
interface keypad_scan_encode_if;
  logic [3:0]  key_row;
  logic        buf_clr;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] digit_buf;

  modport master (
    output key_row, buf_clr,
    input  key_col, key_code, key_valid, key_held, digit_buf
  );

  modport slave (
    input  key_row, buf_clr,
    output key_col, key_code, key_valid, key_held, digit_buf
  );
endinterface

// File: rtl/keypad_scan_encode_scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic CLK50M,
  input  logic RSTn,
  output logic o_tick
);
  localparam int unsigned W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] r_div_cnt;

  assign o_tick = (r_div_cnt == W'(SCAN_DIV - 1));

  // Count 0..SCAN_DIV-1 and wrap.
  always_ff @(posedge CLK50M) begin
    if (!RSTn)       r_div_cnt <= '0;
    else if (o_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end
endmodule

// File: rtl/keypad_scan_encode.sv
// 4x4 keypad scanner: column scan, frame-level debounce, hex encode, digit buffer.
module keypad_scan_encode
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = SCAN_DIV_1MS,
  parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic CLK50M,
  input  logic RSTn,
  keypad_scan_encode_if.slave bus
);
  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic          w_tick;
  logic          w_frame_end;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_acc_n;
  logic [3:0]    r_acc_code;
  logic [2:0]    w_col_n;
  logic [1:0]    w_row_idx;
  logic [2:0]    w_tot_n;
  frame_res_e    w_res;
  logic [3:0]    w_res_code;
  kp_state_e     r_state, w_state_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          w_accept;
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic [31:0]   r_digit_buf;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .CLK50M (CLK50M),
    .RSTn   (RSTn),
    .o_tick (w_tick)
  );

  assign w_frame_end = w_tick && (r_col_idx == 2'd3);
  assign w_cnt_inc   = r_cnt + 1'b1;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge CLK50M) begin
    if (!RSTn) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= bus.key_row;
      r_row_s2 <= r_row_s1;
    end
  end

  // Advance the driven column on every tick.
  always_ff @(posedge CLK50M) begin
    if (!RSTn)       r_col_idx <= '0;
    else if (w_tick) r_col_idx <= r_col_idx + 2'd1;
  end

  // Fold the current column's sample into the running frame result.
  always_comb begin
    w_col_n    = count_low(r_row_s2);
    w_row_idx  = low_zero_idx(r_row_s2);
    w_tot_n    = {1'b0, r_acc_n} + w_col_n;
    w_res_code = (w_col_n != 3'd0) ? {w_row_idx, r_col_idx} : r_acc_code;
    if (w_tot_n == 3'd0)      w_res = NONE;
    else if (w_tot_n == 3'd1) w_res = SINGLE;
    else                      w_res = MULTI;
  end

  // Per-frame key count (saturating at 2) and the code of the first key seen.
  always_ff @(posedge CLK50M) begin
    if (!RSTn) begin
      r_acc_n    <= '0;
      r_acc_code <= '0;
    end else if (w_tick) begin
      if (w_frame_end)          r_acc_n <= '0;
      else if (w_tot_n >= 3'd2) r_acc_n <= 2'd2;
      else                      r_acc_n <= w_tot_n[1:0];
      if (w_col_n != 3'd0) r_acc_code <= {w_row_idx, r_col_idx};
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK50M) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Debounce next-state logic; moves only at frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        IDLE: begin
          if (w_res == SINGLE) begin
            w_state_nxt = DEBOUNCE;
            w_cand_nxt  = w_res_code;
            w_cnt_nxt   = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (w_res == SINGLE && w_res_code == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        PRESSED: begin
          if (w_res == NONE) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = CW'(1);
          end
        end
        RELEASE: begin
          if (w_res == NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CW'(DEBOUNCE_FRAMES)) w_state_nxt = IDLE;
          end else begin
            w_state_nxt = PRESSED;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Registered strobe, key code and digit buffer; a clear that lands on an
  // accept keeps the new digit only.
  always_ff @(posedge CLK50M) begin
    if (!RSTn) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_digit_buf <= '0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= r_cand;
      if (bus.buf_clr)   r_digit_buf <= w_accept ? {28'h0, r_cand} : '0;
      else if (w_accept) r_digit_buf <= {r_digit_buf[27:0], r_cand};
    end
  end

  assign bus.key_col   = ~(4'b0001 << r_col_idx);
  assign bus.key_held  = (r_state == PRESSED) || (r_state == RELEASE);
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;
  assign bus.digit_buf = r_digit_buf;
endmodule

// File: tb/tb_keypad_scan_encode.sv
// Randomized + directed bench for keypad_scan_encode against a frame-level model.
module tb_keypad_scan_encode;
  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FC = 4 * SD;

  logic CLK50M = 1'b0;
  logic RSTn   = 1'b0;
  logic [15:0] pressed = '0;

  keypad_scan_encode_if ifc ();

  keypad_scan_encode #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .CLK50M (CLK50M),
    .RSTn   (RSTn),
    .bus    (ifc)
  );

  always #10 CLK50M = ~CLK50M;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    ifc.key_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!ifc.key_col[c] && pressed[r*4+c]) ifc.key_row[r] = 1'b0;
  end

  int n_vec = 0, n_miss = 0, n_strobe = 0;
  int e = 0;
  bit m_held = 0;
  int m_streak = 0, m_rel = 0;
  logic [3:0]  m_cand = '0, m_code = '0;
  logic [31:0] m_buf = '0;
  bit m_valid = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; m_held = 0; m_streak = 0; m_rel = 0;
    m_cand = '0; m_code = '0; m_buf = '0; m_valid = 0;
  endtask

  // Frame-level behaviour: count keys in the frame, track streaks of the same key.
  task automatic model_frame(output bit acc);
    int k, idx;
    k = $countones(pressed);
    idx = -1;
    acc = 0;
    for (int i = 0; i < 16; i++) if (pressed[i]) idx = i;
    if (!m_held) begin
      if (k == 1 && m_streak > 0 && idx == int'(m_cand)) m_streak++;
      else if (k == 1 && m_streak == 0) begin m_cand = 4'(idx); m_streak = 1; end
      else m_streak = 0;
      if (m_streak == DF) begin acc = 1; m_held = 1; m_rel = 0; m_streak = 0; end
    end else begin
      if (k == 0) begin m_rel++; if (m_rel == DF) m_held = 0; end
      else m_rel = 0;
    end
  endtask

  task automatic step(input logic clr);
    bit acc;
    logic [3:0] ec;
    ifc.buf_clr = clr;
    @(posedge CLK50M);
    e++;
    acc = 0;
    if (e % FC == 0) model_frame(acc);
    if (clr)      m_buf = acc ? {28'h0, m_cand} : 32'h0;
    else if (acc) m_buf = {m_buf[27:0], m_cand};
    if (acc) m_code = m_cand;
    m_valid = acc;
    @(negedge CLK50M);
    ifc.buf_clr = 1'b0;
    if (ifc.key_valid) n_strobe++;
    ec = 4'hF;
    ec[(e / SD) % 4] = 1'b0;
    check_eq("key_col",   32'(ifc.key_col),   32'(ec));
    check_eq("key_valid", 32'(ifc.key_valid), 32'(m_valid));
    check_eq("key_held",  32'(ifc.key_held),  32'(m_held));
    check_eq("key_code",  32'(ifc.key_code),  32'(m_code));
    check_eq("digit_buf", ifc.digit_buf,      m_buf);
  endtask

  task automatic run_frame(input logic [15:0] mask, input bit clr_last, input bit rnd_clr);
    pressed = mask;
    for (int i = 0; i < FC; i++)
      step(((clr_last && i == FC - 1) || (rnd_clr && $urandom_range(0, 39) == 0)) ? 1'b1 : 1'b0);
  endtask

  task automatic do_reset(input int n);
    RSTn = 1'b0;
    ifc.buf_clr = 1'b0;
    repeat (n) @(posedge CLK50M);
    @(negedge CLK50M);
    model_reset();
    check_eq("rst_key_col",   32'(ifc.key_col),   32'hE);
    check_eq("rst_key_valid", 32'(ifc.key_valid), 32'h0);
    check_eq("rst_key_held",  32'(ifc.key_held),  32'h0);
    check_eq("rst_key_code",  32'(ifc.key_code),  32'h0);
    check_eq("rst_digit_buf", ifc.digit_buf,      32'h0);
    RSTn = 1'b1;
  endtask

  initial begin
    int s0;
    logic [15:0] mk;
    int a, b;
    ifc.buf_clr = 1'b0;
    do_reset(3);

    // Clean press of key 6 (row 1, column 2), then release.
    s0 = n_strobe;
    repeat (3) run_frame(16'h1 << 6, 0, 0);
    check_eq("press_strobes", 32'(n_strobe - s0), 32'd1);
    check_eq("press_code", 32'(ifc.key_code), 32'h6);
    check_eq("press_buf",  ifc.digit_buf, 32'h6);
    check_eq("press_held", 32'(ifc.key_held), 32'h1);
    repeat (2) run_frame('0, 0, 0);
    check_eq("release_held", 32'(ifc.key_held), 32'h0);

    // Bouncing contact is rejected; a stable press is accepted once.
    s0 = n_strobe;
    repeat (3) begin
      run_frame(16'h1 << 5, 0, 0);
      run_frame('0, 0, 0);
    end
    check_eq("bounce_strobes", 32'(n_strobe - s0), 32'd0);
    repeat (3) run_frame(16'h1 << 5, 0, 0);
    repeat (2) run_frame('0, 0, 0);
    check_eq("stable_strobes", 32'(n_strobe - s0), 32'd1);

    // Two rows in the same column: never accepted.
    s0 = n_strobe;
    repeat (3) run_frame(16'h1001, 0, 0);
    check_eq("multi_strobes", 32'(n_strobe - s0), 32'd0);
    check_eq("multi_held", 32'(ifc.key_held), 32'h0);
    run_frame('0, 0, 0);

    // Digit entry 1..9.
    s0 = n_strobe;
    for (int d = 1; d <= 9; d++) begin
      repeat (2) run_frame(16'h1 << d, 0, 0);
      repeat (2) run_frame('0, 0, 0);
    end
    check_eq("seq_strobes", 32'(n_strobe - s0), 32'd9);
    check_eq("seq_buf", ifc.digit_buf, 32'h23456789);

    // Clear coinciding with the accept of key A, then a standalone clear.
    run_frame(16'h1 << 10, 0, 0);
    run_frame(16'h1 << 10, 1, 0);
    check_eq("clr_accept_buf", ifc.digit_buf, 32'h0000000A);
    repeat (2) run_frame('0, 0, 0);
    step(1'b1);
    check_eq("clr_alone_buf", ifc.digit_buf, 32'h0);
    for (int i = 1; i < FC; i++) step(1'b0);

    // Randomized frame sequences with sporadic clears.
    repeat (80) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mk = '0;
        4, 5, 6, 7: mk = 16'h1 << a;
        default:    mk = (16'h1 << a) | (16'h1 << b);
      endcase
      repeat ($urandom_range(1, 4)) run_frame(mk, 0, 1);
    end
    repeat (2) run_frame('0, 0, 0);

    // Reset in the middle of a debounce discards the progress.
    run_frame(16'h1 << 7, 0, 0);
    pressed = 16'h1 << 7;
    repeat (8) step(1'b0);
    do_reset(2);
    s0 = n_strobe;
    run_frame(16'h1 << 7, 0, 0);
    check_eq("rst_mid_strobes", 32'(n_strobe - s0), 32'd0);
    check_eq("rst_mid_held", 32'(ifc.key_held), 32'h0);
    run_frame(16'h1 << 7, 0, 0);
    check_eq("rst_after_strobes", 32'(n_strobe - s0), 32'd1);
    check_eq("rst_after_code", 32'(ifc.key_code), 32'h7);
    repeat (2) run_frame('0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/keypad_scan_encode.md
# keypad_scan_encode

Input-side counterpart of the 8-digit seven-segment scan display: scans a 4x4 active-low matrix keypad one column at a time, debounces presses frame by frame and encodes them as 4-bit hex codes. Accepted keys are emitted as a one-cycle strobe and shifted into an 8-digit nibble buffer that connects directly to the display's eight 4-bit digit inputs.

## Interface
- SCAN_DIV, 50000: clock cycles per column dwell (1 ms at 50 MHz); legal range is at least 4.
- DEBOUNCE_FRAMES, 5: number of consecutive identical frames required to accept a press or a release (one frame is 4 columns, i.e. 4 ms).
- CLK50M  in  1  system clock, 50 MHz.
- RSTn  in  1  reset, synchronous, active-low.
- key_row  in  4  keypad rows, active-low with pull-ups, asynchronous to CLK50M.
- buf_clr  in  1  synchronous clear of digit_buf.
- key_col  out  4  column drive, active-low, exactly one bit low at a time.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle strobe when a key is accepted.
- key_held  out  1  high while the accepted key is still pressed.
- digit_buf  out  32  8 nibbles; [3:0] holds the newest digit and [31:28] the oldest.

## Operation
- **Synchronizer:** key_row passes through a 2-flop synchronizer before any use.
- **Divider:** div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt == SCAN_DIV-1).
- **Column scan:** col_idx (2 bits) increments on tick and wraps 3 to 0. key_col = ~(4'b0001 << col_idx).
- **Sampling:** on tick, the synchronized rows are sampled for the current col_idx. This gives SCAN_DIV-2 cycles of settling after each column change.
- **Key code:** code = {row_idx[1:0], col_idx[1:0]}, where row_idx is the low bit of key_row that reads 0.
- **Frame result:** evaluated on the tick with col_idx==3. The result is NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (2 or more keys, in any columns).
- **FSM (advances only at frame end):**
  - IDLE:
    - SINGLE → DEBOUNCE, with cand=code and cnt=1.
    - Anything else → stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) → cnt++. When cnt reaches DEBOUNCE_FRAMES → PRESSED (accept).
    - SINGLE(other code), NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE, with cnt=1.
    - SINGLE or MULTI → stay; no new acceptance.
  - RELEASE:
    - NONE → cnt++. When cnt reaches DEBOUNCE_FRAMES → IDLE.
    - Any press → PRESSED; no new strobe.
- **Accept actions:** key_code ← cand, key_valid pulses, digit_buf ← {digit_buf[27:0], cand}.
- **key_held:** = (state == PRESSED or RELEASE).
- **buf_clr:**
  - On its own, digit_buf ← 0.
  - If it coincides with an accept, digit_buf ← {28'h0, cand}.

## Timing
- **Reset values:**
  - key_col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, digit_buf = 0.
  - div_cnt = 0, col_idx = 0, state = IDLE.
- **Reset mid-operation:** a partial frame and any debounce progress are discarded. No strobe is generated on reset exit.
- **Strobe timing:** key_valid is registered and goes high in the cycle after the frame-end tick that completes debounce. It is never high for 2 consecutive cycles.
- **Press latency:** from the first frame containing the key to key_valid is DEBOUNCE_FRAMES frames + 1 cycle, plus up to 2 sync cycles and up to 1 frame of alignment.
- **Register update timing:** key_code, digit_buf and key_held change in the same cycle as key_valid.
- **Release:** key_held falls 1 cycle after the tick that completes the release count.

## Structure
- **Shared package `keypad_pkg`:**
  - State enum: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - Frame-result enum: NONE, SINGLE, MULTI.
  - Default constants SCAN_DIV_1MS = 50000 and DEBOUNCE_FRAMES_DEF = 5.
- **Sub-module `scan_tick_gen`:** parameterized divider producing tick. The display scan driver can reuse it.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=2.
- **Reset:** hold RSTn=0 for 3 cycles, then release → key_col=1110 and all outputs 0. key_col rotates 1110→1101→1011→0111 every 4 cycles.
- **Clean press:** hold row 1 low while column 2 is driven, for 3 frames → one key_valid pulse, key_code=4'h6, digit_buf=32'h6, key_held=1. On release for 2 frames → key_held=0.
- **Bounce rejected:** press for 1 frame, release for 1 frame, repeated → no key_valid. A stable press thereafter is accepted once.
- **Multiple keys:** rows 0 and 3 both pressed in the same frame → no strobe; state stays IDLE.
- **Digit sequence:** enter 1,2,…,9 → digit_buf=32'h23456789; 9 strobes in total.
- **Clear collision:** assert buf_clr in the key_valid cycle for key 0xA → digit_buf=32'h0000000A. A later standalone buf_clr gives digit_buf=0.
